// File: rtl/ppm_pkg.sv
// Shared types and constants for the PPM receiver front end.
package ppm_pkg;

    typedef enum logic {
        HUNT = 1'b0,
        RUN  = 1'b1
    } ppm_state_t;

    localparam int DEF_SYNC_TICKS    = 200;
    localparam int DEF_TIMEOUT_TICKS = 2000;

    function automatic int cnt_width(input int timeout_ticks);
        return $clog2(timeout_ticks + 1);
    endfunction

endpackage

// File: rtl/ppm_edge_sync.sv
// Two-flop synchroniser for an asynchronous pin, plus a delay flop and a registered rising-edge pulse.
module ppm_edge_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic rise
);

    logic sync1;
    logic sync2;
    logic dly;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            dly   <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= async_in;
            sync2 <= sync1;
            dly   <= sync2;
            rise  <= sync2 & ~dly;
        end
    end

endmodule

// File: rtl/ppm_frame_decoder.sv
// PPM frame decoder: times rise-to-rise gaps in prescaled ticks and publishes double-buffered frames.
// Optional failsafe load on signal loss is enabled by defining PPM_FAILSAFE_EN.
//
//   state | meaning
//   HUNT  | waiting for a sync gap; pulses are ignored
//   RUN   | collecting channel pulses into the shadow bank
module ppm_frame_decoder
    import ppm_pkg::*;
#(
    parameter int NUM_CHANNELS   = 8,
    parameter int WIDTH          = 8,
    parameter int CLK_DIV        = 64,
    parameter int SYNC_TICKS     = DEF_SYNC_TICKS,
    parameter int TIMEOUT_TICKS  = DEF_TIMEOUT_TICKS,
    parameter int FAILSAFE_VALUE = 0
) (
    input  logic                                 clk,
    input  logic                                 reset_n,
    input  logic                                 ppm_signal,
    output logic [NUM_CHANNELS-1:0][WIDTH-1:0]   channels,
    output logic                                 frame_valid,
    output logic                                 frame_error,
    output logic                                 signal_lost,
    output logic                                 locked
);

    localparam int CNT_W   = cnt_width(TIMEOUT_TICKS);
    localparam int PRE_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int IDX_W   = $clog2(NUM_CHANNELS + 1);
    localparam int MAX_VAL = (2 ** WIDTH) - 1;
    localparam logic [WIDTH-1:0] FS_VAL = WIDTH'(FAILSAFE_VALUE);

`ifdef PPM_FAILSAFE_EN
    localparam bit FAILSAFE_EN = 1'b1;
`else
    localparam bit FAILSAFE_EN = 1'b0;
`endif

    logic                                edge_pulse;
    logic [PRE_W-1:0]                    presc_q;
    logic [CNT_W-1:0]                    interval_q;
    logic                                tick;
    ppm_state_t                          state_q, state_d;
    logic [IDX_W-1:0]                    idx_q, idx_d;
    logic                                timed_out_q;
    logic [NUM_CHANNELS-1:0][WIDTH-1:0]  shadow_q;
    logic [WIDTH-1:0]                    store_val;
    logic                                is_sync;
    logic                                do_store, do_commit, do_error, do_timeout;

    ppm_edge_sync u_edge_sync (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (ppm_signal),
        .rise     (edge_pulse)
    );

    assign tick      = (presc_q == PRE_W'(CLK_DIV - 1));
    assign is_sync   = (interval_q >= CNT_W'(SYNC_TICKS));
    assign store_val = (int'(interval_q) > MAX_VAL) ? WIDTH'(MAX_VAL) : WIDTH'(interval_q);
    assign locked    = (state_q == RUN);

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        do_store   = 1'b0;
        do_commit  = 1'b0;
        do_error   = 1'b0;
        do_timeout = 1'b0;
        if (edge_pulse) begin
            case (state_q)
                HUNT: begin
                    if (is_sync) begin
                        state_d = RUN;
                        idx_d   = '0;
                    end
                end
                RUN: begin
                    if (!is_sync) begin
                        if (idx_q < IDX_W'(NUM_CHANNELS)) begin
                            do_store = 1'b1;
                            idx_d    = idx_q + IDX_W'(1);
                        end else begin
                            do_error = 1'b1;
                            state_d  = HUNT;
                            idx_d    = '0;
                        end
                    end else begin
                        if (idx_q == IDX_W'(NUM_CHANNELS)) do_commit = 1'b1;
                        else                               do_error  = 1'b1;
                        idx_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end else if (interval_q == CNT_W'(TIMEOUT_TICKS) && !timed_out_q) begin
            // Loss is reported once per silent period; the flag rearms on the next edge.
            do_timeout = 1'b1;
            state_d    = HUNT;
            idx_d      = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            presc_q     <= '0;
            interval_q  <= '0;
            state_q     <= HUNT;
            idx_q       <= '0;
            timed_out_q <= 1'b0;
            shadow_q    <= '0;
            channels    <= '0;
            frame_valid <= 1'b0;
            frame_error <= 1'b0;
            signal_lost <= 1'b1;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            frame_valid <= do_commit;
            frame_error <= do_error;

            if (edge_pulse) begin
                presc_q    <= '0;
                interval_q <= '0;
            end else if (tick) begin
                presc_q <= '0;
                if (interval_q != CNT_W'(TIMEOUT_TICKS))
                    interval_q <= interval_q + CNT_W'(1);
            end else begin
                presc_q <= presc_q + PRE_W'(1);
            end

            if (edge_pulse)      timed_out_q <= 1'b0;
            else if (do_timeout) timed_out_q <= 1'b1;

            for (int i = 0; i < NUM_CHANNELS; i++) begin
                if (do_store && idx_q == IDX_W'(i))
                    shadow_q[i] <= store_val;
            end
            if (do_timeout)
                shadow_q <= '0;

            if (do_commit) begin
                channels    <= shadow_q;
                signal_lost <= 1'b0;
            end else if (do_timeout) begin
                signal_lost <= 1'b1;
                if (FAILSAFE_EN)
                    channels <= {NUM_CHANNELS{FS_VAL}};
            end
        end
    end

endmodule

// File: tb/tb_ppm_frame_decoder.sv
// Scoreboard bench: two decoders (8-bit and 6-bit channels) share one PPM stream; a frame-level model predicts events.
module tb_ppm_frame_decoder;

    localparam int NUM    = 4;
    localparam int SYNC   = 100;
    localparam int TO     = 1000;
    localparam int FS_EXP = 0;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic ppm = 1'b0;

    logic [NUM-1:0][7:0] ch_a;
    logic [NUM-1:0][5:0] ch_b;
    logic fv_a, fe_a, sl_a, lk_a;
    logic fv_b, fe_b, sl_b, lk_b;

    always #5 clk = ~clk;

    ppm_frame_decoder #(
        .NUM_CHANNELS(NUM), .WIDTH(8), .CLK_DIV(1),
        .SYNC_TICKS(SYNC), .TIMEOUT_TICKS(TO), .FAILSAFE_VALUE(FS_EXP)
    ) dut_a (
        .clk(clk), .reset_n(reset_n), .ppm_signal(ppm), .channels(ch_a),
        .frame_valid(fv_a), .frame_error(fe_a), .signal_lost(sl_a), .locked(lk_a)
    );

    ppm_frame_decoder #(
        .NUM_CHANNELS(NUM), .WIDTH(6), .CLK_DIV(1),
        .SYNC_TICKS(SYNC), .TIMEOUT_TICKS(TO), .FAILSAFE_VALUE(FS_EXP)
    ) dut_b (
        .clk(clk), .reset_n(reset_n), .ppm_signal(ppm), .channels(ch_b),
        .frame_valid(fv_b), .frame_error(fe_b), .signal_lost(sl_b), .locked(lk_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        bit is_valid;
        int ch[NUM];
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];

    // Frame-level reference: pulses collected since the last sync, committed frame, loss flag.
    bit m_hunt = 1'b1;
    int m_frame[$];
    int m_comm[NUM];
    bit m_lost = 1'b1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic push_ev(input bit v);
        ev_t e;
        e.is_valid = v;
        e.ch = m_comm;
        q_a.push_back(e);
        q_b.push_back(e);
    endtask

    task automatic model_timeout();
        m_lost = 1'b1;
        m_hunt = 1'b1;
        m_frame.delete();
`ifdef PPM_FAILSAFE_EN
        foreach (m_comm[i]) m_comm[i] = FS_EXP;
`endif
    endtask

    task automatic model_rise(input int gap);
        int t;
        t = (gap > TO) ? TO : gap;
        if (t >= SYNC) begin
            if (!m_hunt) begin
                if (m_frame.size() == NUM) begin
                    foreach (m_comm[i]) m_comm[i] = m_frame[i];
                    m_lost = 1'b0;
                    push_ev(1'b1);
                end else begin
                    push_ev(1'b0);
                end
            end
            m_hunt = 1'b0;
            m_frame.delete();
        end else if (!m_hunt) begin
            m_frame.push_back(t);
            if (m_frame.size() > NUM) begin
                push_ev(1'b0);
                m_hunt = 1'b1;
                m_frame.delete();
            end
        end
    endtask

    task automatic check_levels(input string tag);
        chk({tag, "_locked_a"}, int'(lk_a), int'(!m_hunt));
        chk({tag, "_locked_b"}, int'(lk_b), int'(!m_hunt));
        chk({tag, "_lost_a"}, int'(sl_a), int'(m_lost));
        chk({tag, "_lost_b"}, int'(sl_b), int'(m_lost));
        for (int i = 0; i < NUM; i++) begin
            chk($sformatf("%s_ch_a%0d", tag, i), int'(ch_a[i]), sat(m_comm[i], 255));
            chk($sformatf("%s_ch_b%0d", tag, i), int'(ch_b[i]), sat(m_comm[i], 63));
        end
    endtask

    // Next rise arrives gap+1 cycles after the previous one, i.e. gap ticks at CLK_DIV=1.
    task automatic rise(input int gap);
        repeat (4) @(negedge clk);
        check_levels("lvl");
        ppm = 1'b0;
        if (gap >= TO + 20) begin
            repeat (TO + 10) @(negedge clk);
            model_timeout();
            check_levels("loss");
            repeat (gap - 3 - TO - 10) @(negedge clk);
        end else begin
            repeat (gap - 3) @(negedge clk);
        end
        ppm = 1'b1;
        model_rise(gap);
    endtask

    task automatic apply_reset();
        ppm = 1'b0;
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_q_a_drained", q_a.size(), 0);
        chk("rst_q_b_drained", q_b.size(), 0);
        chk("rst_fv_a", int'(fv_a), 0);
        chk("rst_fe_a", int'(fe_a), 0);
        chk("rst_fv_b", int'(fv_b), 0);
        chk("rst_fe_b", int'(fe_b), 0);
        chk("rst_lost_a", int'(sl_a), 1);
        chk("rst_locked_a", int'(lk_a), 0);
        chk("rst_lost_b", int'(sl_b), 1);
        chk("rst_locked_b", int'(lk_b), 0);
        for (int i = 0; i < NUM; i++) begin
            chk($sformatf("rst_ch_a%0d", i), int'(ch_a[i]), 0);
            chk($sformatf("rst_ch_b%0d", i), int'(ch_b[i]), 0);
        end
        reset_n = 1'b1;
        m_hunt = 1'b1;
        m_frame.delete();
        m_lost = 1'b1;
        foreach (m_comm[i]) m_comm[i] = 0;
    endtask

    always @(negedge clk) begin : mon_a
        ev_t e;
        if (reset_n && (fv_a || fe_a)) begin
            chk("a_valid_error_excl", int'(fv_a & fe_a), 0);
            if (q_a.size() == 0) begin
                chk("a_unexpected_event", 1, 0);
            end else begin
                e = q_a.pop_front();
                chk("a_event_is_valid", int'(fv_a), int'(e.is_valid));
                for (int i = 0; i < NUM; i++)
                    chk($sformatf("a_event_ch%0d", i), int'(ch_a[i]), sat(e.ch[i], 255));
            end
        end
    end

    always @(negedge clk) begin : mon_b
        ev_t e;
        if (reset_n && (fv_b || fe_b)) begin
            chk("b_valid_error_excl", int'(fv_b & fe_b), 0);
            if (q_b.size() == 0) begin
                chk("b_unexpected_event", 1, 0);
            end else begin
                e = q_b.pop_front();
                chk("b_event_is_valid", int'(fv_b), int'(e.is_valid));
                for (int i = 0; i < NUM; i++)
                    chk($sformatf("b_event_ch%0d", i), int'(ch_b[i]), sat(e.ch[i], 63));
            end
        end
    end

    initial begin
        int r;
        int npulse;
        apply_reset();

        // nominal frame
        rise(300);
        rise(50); rise(60); rise(70); rise(80);
        rise(300);

        // boundary: 99 is a channel (saturates on 6-bit), 100 is sync
        rise(99); rise(99); rise(99); rise(99);
        rise(100);

        // short frames
        rise(10); rise(20); rise(100);
        rise(30); rise(40); rise(50); rise(300);
        rise(11); rise(22); rise(33); rise(44); rise(200);

        // long frame, then pulses ignored while hunting, then recovery
        rise(5); rise(6); rise(7); rise(8); rise(9);
        rise(15); rise(25);
        rise(300);
        rise(61); rise(62); rise(63); rise(64); rise(300);

        // loss, then first edge does not clear signal_lost; next frame does
        rise(1200);
        rise(41); rise(42); rise(43); rise(44);
        rise(300);

        // reset mid-frame
        rise(300);
        rise(45); rise(46);
        repeat (6) @(negedge clk);
        apply_reset();
        rise(300);
        rise(71); rise(72); rise(73); rise(74);
        rise(300);

        // randomized frames
        for (int f = 0; f < 20; f++) begin
            r = $urandom_range(0, 9);
            npulse = (r < 6) ? 4 : ((r < 8) ? 3 : 5);
            for (int p = 0; p < npulse; p++)
                rise($urandom_range(4, 99));
            if ($urandom_range(0, 7) == 0) rise(1200);
            else                           rise($urandom_range(100, 400));
        end

        repeat (10) @(negedge clk);
        check_levels("end");
        chk("end_q_a_drained", q_a.size(), 0);
        chk("end_q_b_drained", q_b.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
